serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_sub_fullsub.sv | 13 +
 rtl/serial_sub.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Bit counter needs to reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_fullsub.sv
// One-bit full subtractor cell: D = A - B - B_I, B_O is the borrow out.
module FullSUB (
    input  logic A,
    input  logic B,
    input  logic B_I,
    output logic B_O,
    output logic D
);

    assign D   = A ^ B ^ B_I;
    assign B_O = (~A & B) | (~(A ^ B) & B_I);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor D = A - B - B_IN over WIDTH clocks.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic             B_OUT
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             diff, bo, last;

    FullSUB u_cell (
        .A   (a_sr[0]),
        .B   (b_sr[0]),
        .B_I (brw),
        .B_O (bo),
        .D   (diff)
    );

    // The final difference bit is merged straight into D, so the shift
    // register only has to hold the WIDTH-1 earlier bits.
    assign res_nxt = {diff, res_sr};
    assign last    = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE:  if (START) state_nxt = SHIFT;
            SHIFT: begin
                BUSY = 1'b1;
                if (last) state_nxt = FIN;
            end
            FIN: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            B_OUT  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            OVF    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (START) begin
                    a_sr <= A;
                    b_sr <= B;
                    brw  <= B_IN;
                    cnt  <= '0;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt[WIDTH-1:1];
                    brw    <= bo;
                    if (!last) cnt <= cnt + 1'b1;
                    if (last) begin
                        D     <= res_nxt;
                        B_OUT <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out of it.
                        OVF   <= brw ^ bo;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
